// File: rtl/mac_act_stage.sv
// mac_act_stage: requantize, activate and buffer finished MAC accumulator values.
// Pipeline: stage 1 rounds and shifts, stage 2 applies ReLU and saturation,
// then a show-ahead FIFO hands results to the next layer over valid/ready.
// Optional build macro LEAKY_RELU_EN replaces ReLU with a leaky ReLU (slope 1/8).
module mac_act_stage #(
    parameter int unsigned IN_BITWIDTH  = 32,
    parameter int unsigned OUT_BITWIDTH = 16,
    parameter int unsigned FRAC_SHIFT   = 8,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic signed [IN_BITWIDTH-1:0]     acc_in,
    input  logic                              acc_valid,
    output logic                              acc_ready,
    output logic signed [OUT_BITWIDTH-1:0]    act_out,
    output logic                              act_valid,
    input  logic                              act_ready,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
    output logic                              sat_flag,
    input  logic                              clear_sat
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned RW = IN_BITWIDTH + 1;

    // Half an output LSB; collapses to zero when nothing is shifted out.
    localparam logic signed [RW-1:0] RND  = RW'((RW'(1) << FRAC_SHIFT) >> 1);
    localparam logic signed [RW-1:0] MAXV = RW'((64'(1) << (OUT_BITWIDTH - 1)) - 64'(1));
`ifdef LEAKY_RELU_EN
    localparam logic signed [RW-1:0] MINV = -MAXV - RW'(1);
`endif

    logic                           s1_valid;
    logic signed [RW-1:0]           s1_r;
    logic                           s2_valid;
    logic signed [OUT_BITWIDTH-1:0] s2_y;

    logic [OUT_BITWIDTH-1:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]                  rd_ptr;
    logic [PW-1:0]                  wr_ptr;

    logic                           accept_c;
    logic [CW:0]                    reserved_c;
    logic signed [RW-1:0]           s1_sum_c;
    logic signed [OUT_BITWIDTH-1:0] s2_y_c;
    logic                           s2_sat_c;
`ifdef LEAKY_RELU_EN
    logic signed [RW-1:0]           s2_leak_c;
`endif
    logic                           push_c;
    logic                           pop_c;
    logic [CW-1:0]                  count_after_pop_c;
    logic [CW-1:0]                  count_next_c;
    logic [PW-1:0]                  rd_next_c;

    // Slot reservation: buffered plus in-flight entries must leave room for one more.
    assign reserved_c = (CW+1)'(fifo_count) + (CW+1)'(s1_valid) + (CW+1)'(s2_valid);
    assign acc_ready  = reserved_c < (CW+1)'(FIFO_DEPTH);
    assign accept_c   = acc_valid && acc_ready;

    // Sign-extended add one bit wider so the rounding term can never overflow.
    assign s1_sum_c = RW'(acc_in) + RND;

    // Stage 1: rounding arithmetic right shift (round half toward +inf).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_r <= s1_sum_c >>> FRAC_SHIFT;
            end
        end
    end

    // Stage 2 combinational: activation function and clamp to output range.
    always_comb begin
        s2_y_c   = '0;
        s2_sat_c = 1'b0;
`ifdef LEAKY_RELU_EN
        s2_leak_c = s1_r >>> 3;
`endif
        if (s1_r[RW-1]) begin
`ifdef LEAKY_RELU_EN
            if (s2_leak_c < MINV) begin
                s2_y_c   = MINV[OUT_BITWIDTH-1:0];
                s2_sat_c = 1'b1;
            end else begin
                s2_y_c = s2_leak_c[OUT_BITWIDTH-1:0];
            end
`else
            s2_y_c = '0;
`endif
        end else if (s1_r > MAXV) begin
            s2_y_c   = MAXV[OUT_BITWIDTH-1:0];
            s2_sat_c = 1'b1;
        end else begin
            s2_y_c = s1_r[OUT_BITWIDTH-1:0];
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_y <= s2_y_c;
            end
        end
    end

    // Sticky saturation flag; a new saturation wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sat_flag <= 1'b0;
        end else if (s1_valid && s2_sat_c) begin
            sat_flag <= 1'b1;
        end else if (clear_sat) begin
            sat_flag <= 1'b0;
        end
    end

    // FIFO bookkeeping: stage 2 always pushes; reservation guarantees a free slot.
    assign push_c            = s2_valid;
    assign pop_c             = act_valid && act_ready;
    assign count_after_pop_c = fifo_count - CW'(pop_c);
    assign count_next_c      = count_after_pop_c + CW'(push_c);
    assign rd_next_c         = pop_c ? rd_ptr + PW'(1) : rd_ptr;

    // FIFO storage; contents need no reset since validity lives in the count.
    always_ff @(posedge clk) begin
        if (rstn && push_c) begin
            mem[wr_ptr] <= s2_y;
        end
    end

    // Pointers, occupancy and registered show-ahead head entry.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            act_valid  <= 1'b0;
            act_out    <= '0;
        end else begin
            fifo_count <= count_next_c;
            act_valid  <= (count_next_c != '0);
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            // Head comes from the incoming word when the FIFO would otherwise be empty.
            if (count_next_c != '0) begin
                if (count_after_pop_c == '0) begin
                    act_out <= s2_y;
                end else begin
                    act_out <= mem[rd_next_c];
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_act_stage.sv
// Scoreboard bench for mac_act_stage: directed cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_mac_act_stage;

    localparam int unsigned IW    = 32;
    localparam int unsigned OW    = 16;
    localparam int unsigned FS    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

`ifdef LEAKY_RELU_EN
    localparam longint NEG_EXP = -1;
`else
    localparam longint NEG_EXP = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rstn;
    logic signed [IW-1:0] acc_in;
    logic                 acc_valid;
    logic                 acc_ready;
    logic signed [OW-1:0] act_out;
    logic                 act_valid;
    logic                 act_ready;
    logic [CW-1:0]        fifo_count;
    logic                 sat_flag;
    logic                 clear_sat;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint exp_q[$];
    longint out_val[$];
    longint out_cyc[$];
    bit     log_en  = 1'b0;
    bit     sat_any = 1'b0;
    longint last_out = 0;
    longint cyc = 0;

    mac_act_stage #(
        .IN_BITWIDTH (IW),
        .OUT_BITWIDTH(OW),
        .FRAC_SHIFT  (FS),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .acc_in    (acc_in),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .act_out   (act_out),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .fifo_count(fifo_count),
        .sat_flag  (sat_flag),
        .clear_sat (clear_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    // Reference: round-half-up division by 2^FS, then activation and clamp.
    function automatic void model(input longint acc, output longint y, output bit sat);
        longint d;
        longint r;
        longint maxv;
`ifdef LEAKY_RELU_EN
        longint minv;
`endif
        d    = longint'(1) << FS;
        maxv = (longint'(1) << (OW - 1)) - 1;
        r    = floor_div(acc + d / 2, d);
        sat  = 1'b0;
        y    = r;
        if (r < 0) begin
`ifdef LEAKY_RELU_EN
            minv = -maxv - 1;
            y    = floor_div(r, 8);
            if (y < minv) begin
                y   = minv;
                sat = 1'b1;
            end
`else
            y = 0;
`endif
        end else if (r > maxv) begin
            y   = maxv;
            sat = 1'b1;
        end
    endfunction

    // Monitor: pops expected values on output handshakes, records accepts.
    always @(negedge clk) begin
        longint e;
        longint y;
        bit     s;
        if (rstn) begin
            if (act_valid && act_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %0d, required no output", longint'(act_out));
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard", longint'(act_out), e);
                end
                last_out = longint'(act_out);
                if (log_en) begin
                    out_val.push_back(longint'(act_out));
                    out_cyc.push_back(cyc);
                end
            end
            if (acc_valid && acc_ready) begin
                model(longint'(acc_in), y, s);
                exp_q.push_back(y);
                if (s) sat_any = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one value and hold it until accepted; returns just after the accept edge.
    task automatic send(input logic signed [IW-1:0] v);
        int guard;
        guard     = 0;
        acc_in    = v;
        acc_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (acc_ready) break;
            guard++;
            if (guard > 200) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        step();
        acc_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !act_valid) break;
            guard++;
            if (guard > 300) begin
                check("drain_timeout", longint'(exp_q.size()), 0);
                break;
            end
        end
        step();
    endtask

    function automatic logic signed [IW-1:0] rand_acc();
        int k;
        case ($urandom_range(0, 3))
            0: return IW'($urandom);
            1: return IW'(int'($urandom_range(0, 1 << 24)) - (1 << 23));
            2: begin
                k = int'($urandom_range(0, 200)) - 100;
                return IW'(k * 256 + 127 + int'($urandom_range(0, 1)));
            end
            default: return IW'(32767 * 256 + int'($urandom_range(0, 256)) - 128);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  idx;
        bit  ghost;
        logic signed [IW-1:0] rv [4];

        rstn      = 1'b0;
        acc_in    = '0;
        acc_valid = 1'b0;
        act_ready = 1'b0;
        clear_sat = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        @(negedge clk);
        check("rst_act_out", longint'(act_out), 0);
        check("rst_act_valid", act_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_acc_ready", acc_ready, 1);

        // Round up and latency.
        step();
        act_ready = 1'b1;
        send(384);
        @(negedge clk);
        check("lat_edge1_valid", act_valid, 0);
        @(negedge clk);
        check("lat_edge1b_valid", act_valid, 0);
        @(negedge clk);
        check("lat_edge2_valid", act_valid, 1);
        check("round_up_out", longint'(act_out), 2);
        check("lat_count_one", fifo_count, 1);
        @(negedge clk);
        check("count_after_pop", fifo_count, 0);
        step();

        // Round down.
        send(383);
        wait_idle();
        check("round_down_out", last_out, 1);

        // Saturation, clear, and set-beats-clear.
        send(32'h0100_0000);
        wait_idle();
        check("sat_out", last_out, 32767);
        check("sat_flag_set", sat_flag, 1);
        clear_sat = 1'b1;
        step();
        clear_sat = 1'b0;
        @(negedge clk);
        check("sat_flag_cleared", sat_flag, 0);
        step();
        clear_sat = 1'b1;
        send(32'h0100_0000);
        step();
        clear_sat = 1'b0;
        wait_idle();
        check("sat_set_beats_clear", sat_flag, 1);

        // Negative input.
        clear_sat = 1'b1;
        step();
        clear_sat = 1'b0;
        send(-1000);
        wait_idle();
        check("neg_out", last_out, NEG_EXP);
        check("neg_sat_unchanged", sat_flag, 0);

        // Backpressure: only DEPTH values fit while the consumer stalls.
        act_ready = 1'b0;
        out_val.delete();
        out_cyc.delete();
        log_en    = 1'b1;
        idx       = 0;
        acc_valid = 1'b1;
        acc_in    = 256;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 7) begin
                check("bp_acc_ready_low", acc_ready, 0);
                check("bp_accepted", idx, 4);
                check("bp_fifo_count", fifo_count, 4);
            end
            if (acc_valid && acc_ready) idx++;
            step();
            if (c == 7) act_ready = 1'b1;
            acc_valid = (idx < 6);
            acc_in    = IW'(256 * (idx + 1));
        end
        log_en = 1'b0;
        wait_idle();
        check("bp_out_total", longint'(out_val.size()), 6);
        if (out_val.size() >= 6) begin
            for (int k = 0; k < 6; k++) check("bp_out_order", out_val[k], longint'(k + 1));
            for (int k = 1; k < 4; k++) check("bp_out_consecutive", out_cyc[k] - out_cyc[0], longint'(k));
        end

        // Reset with three buffered entries and one in flight.
        act_ready = 1'b0;
        rv[0] = 32'h0100_0000;
        rv[1] = 1000;
        rv[2] = 2000;
        rv[3] = 3000;
        for (int k = 0; k < 4; k++) begin
            acc_valid = 1'b1;
            acc_in    = rv[k];
            step();
        end
        acc_valid = 1'b0;
        step();
        @(negedge clk);
        check("pre_rst_fifo_count", fifo_count, 3);
        check("pre_rst_sat", sat_flag, 1);
        check("pre_rst_expected", longint'(exp_q.size()), 4);
        step();
        rstn = 1'b0;
        exp_q.delete();
        step();
        rstn = 1'b1;
        @(negedge clk);
        check("mid_rst_act_valid", act_valid, 0);
        check("mid_rst_fifo_count", fifo_count, 0);
        check("mid_rst_sat", sat_flag, 0);
        check("mid_rst_acc_ready", acc_ready, 1);
        step();
        act_ready = 1'b1;
        ghost     = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (act_valid) ghost = 1'b1;
        end
        check("no_ghost_output", ghost, 0);
        step();

        // Randomized traffic against the model.
        clear_sat = 1'b1;
        step();
        clear_sat = 1'b0;
        sat_any   = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            acc_valid = ($urandom_range(0, 9) < 7);
            acc_in    = rand_acc();
            act_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        acc_valid = 1'b0;
        act_ready = 1'b1;
        wait_idle();
        check("rand_drained", longint'(exp_q.size()), 0);
        check("rand_sat_flag", sat_flag, sat_any);
        check("rand_fifo_empty", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
